// File: rtl/fdx_front_end_pkg.sv
// Shared constants for the MIPS-I fetch/decode/execute front end: opcodes, functs,
// the NOP ALU operation and the architectural reset values.
package fdx_front_end_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h80020000;
    localparam logic [31:0] MEM_DEPTH_DEF = 32'h00100000;
    localparam logic [31:0] R29_RESET     = BASE_ADDR_DEF + MEM_DEPTH_DEF;
    localparam logic [31:0] R31_RESET     = 32'hdeadbeef;

    localparam logic [5:0] NOP_OP   = 6'b100001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_SRL    = 6'b000010;
    localparam logic [5:0] F_SRA    = 6'b000011;
    localparam logic [5:0] F_JR     = 6'b001000;
    localparam logic [5:0] F_ADDU   = 6'b100001;
    localparam logic [5:0] F_SUBU   = 6'b100011;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_XOR    = 6'b100110;
    localparam logic [5:0] F_NOR    = 6'b100111;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_SLTU   = 6'b101011;

endpackage

// File: rtl/fdx_regfile.sv
// 32x32 register file, r0 hardwired to zero, two combinational read ports.
// FDX_RF_WRITE_THROUGH_EN makes a same-cycle read of the written register return wb data.
module fdx_regfile
    import fdx_front_end_pkg::*;
#(
    parameter logic [31:0] SP_INIT = R29_RESET,
    parameter logic [31:0] RA_INIT = R31_RESET
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // r0 is never written and resets to zero, so a plain array read is safe.
    always_comb begin
        ra_data = regs_q[ra_addr];
        rb_data = regs_q[rb_addr];
`ifdef FDX_RF_WRITE_THROUGH_EN
        if (wr_en && waddr == ra_addr) ra_data = wdata;
        if (wr_en && waddr == rb_addr) rb_data = wdata;
`endif
    end

endmodule

// File: rtl/fdx_front_end.sv
// MIPS-I fetch/decode/execute front end: PC, register file, F/D decode and
// combinational D/X execute with bypass muxes and branch/jump resolution.
module fdx_front_end
    import fdx_front_end_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [31:0] MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    output logic [31:0] pc_out,
    output logic [31:0] i_address,
    output logic [1:0]  i_access_size,
    output logic        i_rw,
    output logic        i_mem_enable,
    input  logic [31:0] insn,
    output logic [31:0] rA,
    output logic [31:0] rB,
    output logic        br,
    output logic        jp,
    output logic        aluinb,
    output logic        dmwe,
    output logic        rwe,
    output logic        rdst,
    output logic        rwd,
    output logic [5:0]  aluop,
    input  logic [31:0] wb_data,
    input  logic [4:0]  wb_reg,
    input  logic        wb_we,
    input  logic [31:0] pc_dx,
    input  logic [31:0] insn_dx,
    input  logic [31:0] ra_dx,
    input  logic [31:0] rb_dx,
    input  logic        br_dx,
    input  logic        jp_dx,
    input  logic        aluinb_dx,
    input  logic [5:0]  aluop_dx,
    input  logic [31:0] mx_bypass,
    input  logic [31:0] wx_bypass,
    input  logic        do_mx_bypass,
    input  logic        do_wx_bypass,
    input  logic        do_mx_bypass_b,
    input  logic        do_wx_bypass_b,
    output logic [31:0] alu_out,
    output logic [31:0] rb_out,
    output logic [31:0] pc_effective,
    output logic        do_branch
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] op_a, op_b, alu_b, imm_ext, pc_dx4;
    logic [5:0]  opc_dx;
    logic [4:0]  shamt;
    logic        unused_insn_bits;

    assign unused_insn_bits = ^insn[15:6];

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (do_branch)  pc_d = pc_effective;
        else if (stall) pc_d = pc_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_q <= BASE_ADDR;
        else          pc_q <= pc_d;
    end

    assign pc_out        = pc_q;
    assign i_address     = pc_q;
    assign i_rw          = 1'b1;
    assign i_access_size = 2'b00;
    assign i_mem_enable  = reset_n;

    fdx_regfile #(
        .SP_INIT(BASE_ADDR + MEM_DEPTH),
        .RA_INIT(R31_RESET)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .ra_addr (insn[25:21]),
        .rb_addr (insn[20:16]),
        .ra_data (rA),
        .rb_data (rB),
        .we      (wb_we),
        .waddr   (wb_reg),
        .wdata   (wb_data)
    );

    // I-type ops reuse the funct code of their R-type equivalent as aluop.
    always_comb begin
        br = 1'b0; jp = 1'b0; aluinb = 1'b0; dmwe = 1'b0;
        rwe = 1'b0; rdst = 1'b0; rwd = 1'b0; aluop = NOP_OP;
        case (insn[31:26])
            OP_RTYPE: begin
                case (insn[5:0])
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: begin
                        aluop = insn[5:0]; rdst = 1'b1; rwe = 1'b1;
                    end
                    F_JR: begin
                        aluop = insn[5:0]; rdst = 1'b1; jp = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU: begin aluop = F_ADDU; aluinb = 1'b1; rwe = 1'b1; end
            OP_ANDI:  begin aluop = F_AND;  aluinb = 1'b1; rwe = 1'b1; end
            OP_ORI:   begin aluop = F_OR;   aluinb = 1'b1; rwe = 1'b1; end
            OP_XORI:  begin aluop = F_XOR;  aluinb = 1'b1; rwe = 1'b1; end
            OP_SLTI:  begin aluop = F_SLT;  aluinb = 1'b1; rwe = 1'b1; end
            OP_SLTIU: begin aluop = F_SLTU; aluinb = 1'b1; rwe = 1'b1; end
            OP_LUI:   begin aluop = OP_LUI; aluinb = 1'b1; rwe = 1'b1; end
            OP_LW:    begin aluop = F_ADDU; aluinb = 1'b1; rwe = 1'b1; rwd = 1'b1; end
            OP_SW:    begin aluop = F_ADDU; aluinb = 1'b1; dmwe = 1'b1; end
            OP_BEQ, OP_BNE: begin aluop = F_SUBU; br = 1'b1; end
            OP_J:     jp = 1'b1;
            default: ;
        endcase
    end

    assign opc_dx = insn_dx[31:26];
    assign shamt  = insn_dx[10:6];
    assign pc_dx4 = pc_dx + 32'd4;
    assign op_a   = do_mx_bypass   ? mx_bypass : do_wx_bypass   ? wx_bypass : ra_dx;
    assign op_b   = do_mx_bypass_b ? mx_bypass : do_wx_bypass_b ? wx_bypass : rb_dx;
    assign rb_out = op_b;

    always_comb begin
        imm_ext = {{16{insn_dx[15]}}, insn_dx[15:0]};
        if (opc_dx == OP_ANDI || opc_dx == OP_ORI || opc_dx == OP_XORI)
            imm_ext = {16'h0, insn_dx[15:0]};
    end

    assign alu_b = aluinb_dx ? imm_ext : op_b;

    always_comb begin
        alu_out = 32'h0;
        case (aluop_dx)
            F_ADDU: alu_out = op_a + alu_b;
            F_SUBU: alu_out = op_a - alu_b;
            F_AND:  alu_out = op_a & alu_b;
            F_OR:   alu_out = op_a | alu_b;
            F_XOR:  alu_out = op_a ^ alu_b;
            F_NOR:  alu_out = ~(op_a | alu_b);
            F_SLT:  alu_out = {31'h0, $signed(op_a) < $signed(alu_b)};
            F_SLTU: alu_out = {31'h0, op_a < alu_b};
            F_SLL:  alu_out = op_b << shamt;
            F_SRL:  alu_out = op_b >> shamt;
            F_SRA:  alu_out = $unsigned($signed(op_b) >>> shamt);
            F_JR:   alu_out = op_a;
            OP_LUI: alu_out = {insn_dx[15:0], 16'h0};
            default: ;
        endcase
    end

    // Branch condition compares the bypassed register operands, never the immediate.
    always_comb begin
        pc_effective = pc_dx4 + {imm_ext[29:0], 2'b00};
        do_branch    = 1'b0;
        if (jp_dx) begin
            do_branch    = 1'b1;
            pc_effective = (opc_dx == OP_J) ? {pc_dx4[31:28], insn_dx[25:0], 2'b00} : op_a;
        end else if (br_dx) begin
            do_branch = (opc_dx == OP_BNE) ? (op_a != op_b) : (op_a == op_b);
        end
    end

endmodule

// File: tb/tb_fdx_front_end.sv
// Directed self-checking bench for fdx_front_end; expectations go through a queue
// and are popped at each observation point. Honours FDX_RF_WRITE_THROUGH_EN.
module tb_fdx_front_end;

  logic        clock = 1'b0;
  logic        reset_n, stall;
  logic [31:0] pc_out, i_address, insn, rA, rB;
  logic [1:0]  i_access_size;
  logic        i_rw, i_mem_enable;
  logic        br, jp, aluinb, dmwe, rwe, rdst, rwd;
  logic [5:0]  aluop;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we;
  logic [31:0] pc_dx, insn_dx, ra_dx, rb_dx;
  logic        br_dx, jp_dx, aluinb_dx;
  logic [5:0]  aluop_dx;
  logic [31:0] mx_bypass, wx_bypass;
  logic        do_mx_bypass, do_wx_bypass, do_mx_bypass_b, do_wx_bypass_b;
  logic [31:0] alu_out, rb_out, pc_effective;
  logic        do_branch;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  fdx_front_end dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .pc_out(pc_out), .i_address(i_address), .i_access_size(i_access_size),
    .i_rw(i_rw), .i_mem_enable(i_mem_enable), .insn(insn),
    .rA(rA), .rB(rB), .br(br), .jp(jp), .aluinb(aluinb), .dmwe(dmwe),
    .rwe(rwe), .rdst(rdst), .rwd(rwd), .aluop(aluop),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
    .pc_dx(pc_dx), .insn_dx(insn_dx), .ra_dx(ra_dx), .rb_dx(rb_dx),
    .br_dx(br_dx), .jp_dx(jp_dx), .aluinb_dx(aluinb_dx), .aluop_dx(aluop_dx),
    .mx_bypass(mx_bypass), .wx_bypass(wx_bypass),
    .do_mx_bypass(do_mx_bypass), .do_wx_bypass(do_wx_bypass),
    .do_mx_bypass_b(do_mx_bypass_b), .do_wx_bypass_b(do_wx_bypass_b),
    .alu_out(alu_out), .rb_out(rb_out), .pc_effective(pc_effective),
    .do_branch(do_branch)
  );

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic set_ex(input logic [31:0] idx, input logic [5:0] op, input logic inb,
                        input logic [31:0] a, input logic [31:0] b);
    insn_dx = idx; aluop_dx = op; aluinb_dx = inb; ra_dx = a; rb_dx = b;
    br_dx = 1'b0; jp_dx = 1'b0;
    do_mx_bypass = 1'b0; do_wx_bypass = 1'b0; do_mx_bypass_b = 1'b0; do_wx_bypass_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0;
    insn = 32'h03BF0000;  // rs=29, rt=31
    wb_data = 32'h0; wb_reg = 5'd0; wb_we = 1'b0;
    pc_dx = 32'h0; mx_bypass = 32'h0; wx_bypass = 32'h0;
    set_ex(32'h0, 6'h0, 1'b0, 32'h0, 32'h0);

    #12;
    expect_val("reset_pc", 32'h80020000);      check(pc_out);
    expect_val("reset_iaddr", 32'h80020000);   check(i_address);
    expect_val("reset_r29", 32'h80120000);     check(rA);
    expect_val("reset_r31", 32'hdeadbeef);     check(rB);
    expect_val("reset_imem_en", 32'h0);        check({31'h0, i_mem_enable});
    expect_val("reset_irw", 32'h1);            check({31'h0, i_rw});
    expect_val("reset_isize", 32'h0);          check({30'h0, i_access_size});

    @(negedge clock); reset_n = 1'b1;
    #1;
    expect_val("imem_en", 32'h1);              check({31'h0, i_mem_enable});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      expect_val("seq_pc", 32'h80020000 + 32'(4 * i));
      check(pc_out);
    end
    @(negedge clock); stall = 1'b1;
    @(posedge clock); #1;
    expect_val("stall_pc", 32'h8002000C);      check(pc_out);
    @(negedge clock); stall = 1'b0;
    @(posedge clock); #1;
    expect_val("unstall_pc", 32'h80020010);    check(pc_out);

    // Decode
    @(negedge clock); insn = 32'h24020005;  // ADDIU r2,r0,5
    #1;
    expect_val("addiu_aluinb", 32'h1);         check({31'h0, aluinb});
    expect_val("addiu_rwe", 32'h1);            check({31'h0, rwe});
    expect_val("addiu_rdst", 32'h0);           check({31'h0, rdst});
    expect_val("addiu_aluop", 32'h21);         check({26'h0, aluop});
    insn = 32'h0C000000;  #1;  // JAL -> NOP
    expect_val("jal_ctrl", 32'h0);             check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});
    expect_val("jal_aluop", 32'h21);           check({26'h0, aluop});
    insn = 32'h8C430004;  #1;  // LW
    expect_val("lw_ctrl", 32'b0010101);        check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});
    insn = 32'hAC430004;  #1;  // SW
    expect_val("sw_ctrl", 32'b0011000);        check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});
    insn = 32'h00221823;  #1;  // SUBU r3,r1,r2
    expect_val("subu_ctrl", 32'b0000110);      check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});
    expect_val("subu_aluop", 32'h23);          check({26'h0, aluop});
    insn = 32'h10220003;  #1;  // BEQ
    expect_val("beq_ctrl", 32'b1000000);       check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});
    insn = 32'h03E00008;  #1;  // JR r31
    expect_val("jr_ctrl", 32'b0100010);        check({25'h0, br, jp, aluinb, dmwe, rwe, rdst, rwd});

    // Execute
    set_ex(32'h24020005, 6'h21, 1'b1, 32'h0, 32'h0); #1;
    expect_val("addiu_exec", 32'h5);           check(alu_out);
    set_ex(32'h0, 6'h23, 1'b0, 32'd10, 32'd3); #1;
    expect_val("subu_exec", 32'd7);            check(alu_out);
    set_ex(32'h0, 6'h2A, 1'b0, 32'hFFFFFFFF, 32'h1); #1;
    expect_val("slt_signed", 32'h1);           check(alu_out);
    set_ex(32'h0, 6'h2B, 1'b0, 32'hFFFFFFFF, 32'h1); #1;
    expect_val("sltu_unsigned", 32'h0);        check(alu_out);
    set_ex(32'h00000103, 6'h03, 1'b0, 32'h0, 32'h80000000); #1;  // SRA by 4
    expect_val("sra_exec", 32'hF8000000);      check(alu_out);
    set_ex(32'h34008000, 6'h25, 1'b1, 32'h1, 32'h0); #1;  // ORI zero-ext
    expect_val("ori_zext", 32'h00008001);      check(alu_out);
    set_ex(32'h2400FFFF, 6'h21, 1'b1, 32'h5, 32'h0); #1;  // ADDIU sign-ext
    expect_val("addiu_sext", 32'h00000004);    check(alu_out);
    set_ex(32'h3C001234, 6'h0F, 1'b1, 32'h0, 32'h0); #1;
    expect_val("lui_exec", 32'h12340000);      check(alu_out);

    // Bypass priority
    set_ex(32'h0, 6'h21, 1'b0, 32'd1, 32'd0);
    mx_bypass = 32'd7; wx_bypass = 32'd9;
    do_mx_bypass = 1'b1; do_wx_bypass = 1'b1; #1;
    expect_val("byp_mx_prio", 32'd7);          check(alu_out);
    do_mx_bypass = 1'b0; #1;
    expect_val("byp_wx", 32'd9);               check(alu_out);
    do_wx_bypass_b = 1'b1; do_mx_bypass_b = 1'b1; #1;
    expect_val("byp_b_mx", 32'd7);             check(rb_out);
    do_mx_bypass_b = 1'b0; #1;
    expect_val("byp_b_wx", 32'd9);             check(rb_out);

    // Branch resolution; stall asserted too so the branch must win
    @(negedge clock);
    set_ex(32'h10000003, 6'h23, 1'b0, 32'd5, 32'd5);
    pc_dx = 32'h80020010; br_dx = 1'b1; stall = 1'b1;
    #1;
    expect_val("beq_taken", 32'h1);            check({31'h0, do_branch});
    expect_val("beq_target", 32'h80020020);    check(pc_effective);
    @(posedge clock); #1;
    expect_val("beq_redirect", 32'h80020020);  check(pc_out);
    @(negedge clock); stall = 1'b0;
    set_ex(32'h14000003, 6'h23, 1'b0, 32'd5, 32'd5); br_dx = 1'b1; #1;
    expect_val("bne_not_taken", 32'h0);        check({31'h0, do_branch});
    set_ex(32'h08000010, 6'h21, 1'b0, 32'd0, 32'd0); jp_dx = 1'b1; #1;
    expect_val("j_target", 32'h80000040);      check(pc_effective);
    expect_val("j_taken", 32'h1);              check({31'h0, do_branch});
    set_ex(32'h03E00008, 6'h08, 1'b0, 32'h80020100, 32'd0); jp_dx = 1'b1; #1;
    expect_val("jr_target", 32'h80020100);     check(pc_effective);
    @(posedge clock); #1;
    expect_val("jr_redirect", 32'h80020100);   check(pc_out);
    @(negedge clock); set_ex(32'h0, 6'h0, 1'b0, 32'h0, 32'h0);

    // Register file write / read-during-write
    insn = 32'h00A00000;  // rs=5
    wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234; #1;
`ifdef FDX_RF_WRITE_THROUGH_EN
    expect_val("rf_same_cycle", 32'h1234);
`else
    expect_val("rf_same_cycle", 32'h0);
`endif
    check(rA);
    @(posedge clock); #1;
    expect_val("rf_after_edge", 32'h1234);     check(rA);
    @(negedge clock);
    insn = 32'h00000000; wb_reg = 5'd0; wb_data = 32'hFFFFFFFF;
    @(posedge clock); #1;
    expect_val("rf_r0_ignored", 32'h0);        check(rA);
    @(negedge clock); wb_we = 1'b0;

    if (exp_q.size() != 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
